swc_fabric_sink: RTL and testbench

- Pipelined Wishbone fabric slave. It is the receive end of the 16-bit switch fabric driven by one swc_core output port (src_* side).
- Accepts data, status, OOB and user beats and delimits frames by cyc.
- Buffers data words with SOF/EOF/error tags in a FIFO and presents them on a valid/ready stream towards the endpoint TX path.
- One instance per switch output port.

---
 rtl/swc_fabric_sink_pkg.sv | 26 ++
 rtl/swc_fabric_sink_if.sv | 38 +++
 rtl/swc_fabric_sink_fifo.sv | 50 +++++
 rtl/swc_fabric_sink.sv | 210 +++++++++++++++++++++
 tb/tb_swc_fabric_sink.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/swc_fabric_sink_pkg.sv
// Shared types and constants for the fabric sink: beat-type codes, FIFO entry layout, FSM states.
package swc_sink_pkg;

  localparam logic [1:0] c_WRF_DATA   = 2'b00;
  localparam logic [1:0] c_WRF_STATUS = 2'b01;
  localparam logic [1:0] c_WRF_OOB    = 2'b10;
  localparam logic [1:0] c_WRF_USER   = 2'b11;

  localparam int c_WRF_STATUS_ERR_BIT = 1;

  typedef struct packed {
    logic        sof;
    logic        eof;
    logic        err;
    logic [1:0]  sel;
    logic [15:0] dat;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    FRAME     = 2'd2,
    FLUSH     = 2'd3
  } sink_state_e;

endpackage

// File: rtl/swc_fabric_sink_if.sv
// Fabric sink bundle: pipelined Wishbone receive side plus the valid/ready word stream.
// slave = the sink itself, master = the fabric source / stream consumer side.
interface swc_fabric_sink_if;

  logic [15:0] snk_dat_i;
  logic [1:0]  snk_adr_i;
  logic [1:0]  snk_sel_i;
  logic        snk_cyc_i;
  logic        snk_stb_i;
  logic        snk_we_i;
  logic        snk_stall_o;
  logic        snk_ack_o;
  logic        snk_err_o;
  logic        snk_rty_o;

  logic [15:0] out_dat_o;
  logic [1:0]  out_sel_o;
  logic        out_sof_o;
  logic        out_eof_o;
  logic        out_err_o;
  logic        out_valid_o;
  logic        out_ready_i;

  modport slave (
    input  snk_dat_i, snk_adr_i, snk_sel_i, snk_cyc_i, snk_stb_i, snk_we_i,
    output snk_stall_o, snk_ack_o, snk_err_o, snk_rty_o,
    output out_dat_o, out_sel_o, out_sof_o, out_eof_o, out_err_o, out_valid_o,
    input  out_ready_i
  );

  modport master (
    output snk_dat_i, snk_adr_i, snk_sel_i, snk_cyc_i, snk_stb_i, snk_we_i,
    input  snk_stall_o, snk_ack_o, snk_err_o, snk_rty_o,
    input  out_dat_o, out_sel_o, out_sof_o, out_eof_o, out_err_o, out_valid_o,
    output out_ready_i
  );

endinterface

// File: rtl/swc_fabric_sink_fifo.sv
// Synchronous first-word-fall-through FIFO of tagged fabric words; head is zeroed while empty.
module swc_sink_fifo
  import swc_sink_pkg::*;
#(
  parameter int g_depth = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  fifo_entry_t                wdata,
  input  logic                       pop,
  output fifo_entry_t                rdata,
  output logic [$clog2(g_depth):0]   count,
  output logic                       full,
  output logic                       empty
);

  localparam int c_aw = $clog2(g_depth);
  localparam int c_cw = c_aw + 1;

  fifo_entry_t      mem [g_depth];
  logic [c_aw-1:0]  wr_ptr;
  logic [c_aw-1:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == c_cw'(g_depth));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + c_aw'(1);
      if (do_pop)  rd_ptr <= rd_ptr + c_aw'(1);
      count <= count + c_cw'(do_push) - c_cw'(do_pop);
    end
  end

endmodule

// File: rtl/swc_fabric_sink.sv
// Receive end of the 16-bit switch fabric: frames delimited by cyc, words tagged and queued.
// Optional SWC_SINK_STATS_EN adds saturating ok/error frame counters.
//
//   state     | meaning
//   WAIT_IDLE | after reset: ack and drop beats until cyc is low
//   IDLE      | between frames; cyc high opens a frame
//   FRAME     | collecting beats; the last data word waits in the stage register
//   FLUSH     | frame closed but the FIFO was full; retry the final push
module swc_fabric_sink
  import swc_sink_pkg::*;
#(
  parameter int g_fifo_depth  = 16,
  parameter int g_fifo_margin = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  swc_fabric_sink_if.slave   bus
`ifdef SWC_SINK_STATS_EN
  ,
  output logic [15:0]        frames_ok_o,
  output logic [15:0]        frames_err_o
`endif
);

  localparam int c_cw = $clog2(g_fifo_depth) + 1;
  localparam logic [c_cw-1:0] c_stall_lvl = c_cw'(g_fifo_depth - g_fifo_margin);

  localparam logic [1:0] ST_WAIT_IDLE = 2'(WAIT_IDLE);
  localparam logic [1:0] ST_IDLE      = 2'(IDLE);
  localparam logic [1:0] ST_FRAME     = 2'(FRAME);
  localparam logic [1:0] ST_FLUSH     = 2'(FLUSH);

  logic [1:0]      state, state_n;
  logic            stage_vld, stage_vld_n;
  logic [15:0]     stage_dat, stage_dat_n;
  logic [1:0]      stage_sel, stage_sel_n;
  logic            sof_pend, sof_pend_n;
  logic            err_flag, err_flag_n;
  logic            stall_q, ack_q, err_q;

  logic            accept, wr_beat, in_frame, sof_eff;
  logic            push, pop_fire, push_ok;
  fifo_entry_t     push_ent, head;
  logic [c_cw-1:0] count, count_nxt;
  logic            full, empty;

  assign accept   = bus.snk_cyc_i & bus.snk_stb_i & ~stall_q;
  assign wr_beat  = accept & bus.snk_we_i;
  assign in_frame = bus.snk_cyc_i & ((state == ST_IDLE) | (state == ST_FRAME));
  // the first beat may arrive in the very cycle cyc rises, before sof_pend is set
  assign sof_eff  = (state == ST_IDLE) | sof_pend;
  assign pop_fire = bus.out_ready_i & ~empty;
  assign push_ok  = ~full | pop_fire;

  always_comb begin
    state_n     = state;
    stage_vld_n = stage_vld;
    stage_dat_n = stage_dat;
    stage_sel_n = stage_sel;
    sof_pend_n  = sof_pend;
    err_flag_n  = err_flag;
    push        = 1'b0;
    push_ent    = '{sof: sof_eff, eof: 1'b0, err: 1'b0, sel: stage_sel, dat: stage_dat};

    case (state)
      ST_WAIT_IDLE: begin
        if (!bus.snk_cyc_i) state_n = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.snk_cyc_i) begin
          state_n    = ST_FRAME;
          err_flag_n = 1'b0;
          sof_pend_n = 1'b1;
        end
      end
      ST_FRAME: begin
        if (!bus.snk_cyc_i) begin
          if (!stage_vld) begin
            state_n = ST_IDLE;
          end else if (push_ok) begin
            push         = 1'b1;
            push_ent.eof = 1'b1;
            push_ent.err = err_flag;
            stage_vld_n  = 1'b0;
            state_n      = ST_IDLE;
          end else begin
            state_n = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (push_ok) begin
          push         = 1'b1;
          push_ent.eof = 1'b1;
          push_ent.err = err_flag;
          stage_vld_n  = 1'b0;
          state_n      = ST_IDLE;
        end
      end
      default: state_n = ST_WAIT_IDLE;
    endcase

    if (in_frame && wr_beat) begin
      case (bus.snk_adr_i)
        c_WRF_DATA: begin
          if (bus.snk_sel_i == 2'b00) begin
            err_flag_n = 1'b1;
          end else begin
            if (stage_vld) begin
              push       = push_ok;
              sof_pend_n = 1'b0;
              // a partial word is only legal as the frame's last word
              if (stage_sel != 2'b11) err_flag_n = 1'b1;
            end
            stage_vld_n = 1'b1;
            stage_dat_n = bus.snk_dat_i;
            stage_sel_n = bus.snk_sel_i;
          end
        end
        c_WRF_STATUS: begin
          if (bus.snk_dat_i[c_WRF_STATUS_ERR_BIT]) err_flag_n = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign count_nxt = count + c_cw'(push) - c_cw'(pop_fire);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_WAIT_IDLE;
      stage_vld <= 1'b0;
      stage_dat <= '0;
      stage_sel <= '0;
      sof_pend  <= 1'b0;
      err_flag  <= 1'b0;
      stall_q   <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_n;
      stage_vld <= stage_vld_n;
      stage_dat <= stage_dat_n;
      stage_sel <= stage_sel_n;
      sof_pend  <= sof_pend_n;
      err_flag  <= err_flag_n;
      stall_q   <= (count_nxt >= c_stall_lvl) | (state_n == ST_FLUSH);
      ack_q     <= wr_beat;
      err_q     <= accept & ~bus.snk_we_i;
    end
  end

  swc_sink_fifo #(.g_depth(g_fifo_depth)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .wdata (push_ent),
    .pop   (bus.out_ready_i),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign bus.snk_stall_o = stall_q;
  assign bus.snk_ack_o   = ack_q;
  assign bus.snk_err_o   = err_q;
  assign bus.snk_rty_o   = 1'b0;

  assign bus.out_dat_o   = head.dat;
  assign bus.out_sel_o   = head.sel;
  assign bus.out_sof_o   = head.sof;
  assign bus.out_eof_o   = head.eof;
  assign bus.out_err_o   = head.err;
  assign bus.out_valid_o = ~empty;

`ifdef SWC_SINK_STATS_EN
  logic        close_evt, close_err, close_q, close_err_q;
  logic [15:0] ok_cnt, err_cnt;

  // a frame with no data words closes straight to IDLE and counts as an error
  assign close_evt = ((state == ST_FRAME) & ~bus.snk_cyc_i & (~stage_vld | push_ok)) |
                     ((state == ST_FLUSH) & push_ok);
  assign close_err = ~stage_vld | err_flag;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      close_q     <= 1'b0;
      close_err_q <= 1'b0;
      ok_cnt      <= '0;
      err_cnt     <= '0;
    end else begin
      close_q     <= close_evt;
      close_err_q <= close_err;
      if (close_q) begin
        if (close_err_q) begin
          if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end else begin
          if (ok_cnt != 16'hFFFF) ok_cnt <= ok_cnt + 16'd1;
        end
      end
    end
  end

  assign frames_ok_o  = ok_cnt;
  assign frames_err_o = err_cnt;
`endif

endmodule

// File: tb/tb_swc_fabric_sink.sv
// Bench for swc_fabric_sink: frame-level model of expected words plus per-cycle ack/err/output compare.
module tb_swc_fabric_sink;
  import swc_sink_pkg::*;

  typedef struct packed {
    logic [1:0]  adr;
    logic [1:0]  sel;
    logic [15:0] dat;
    logic        we;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  swc_fabric_sink_if bus();

`ifdef SWC_SINK_STATS_EN
  logic [15:0] frames_ok, frames_err;
`endif

  swc_fabric_sink #(.g_fifo_depth(16), .g_fifo_margin(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef SWC_SINK_STATS_EN
    ,
    .frames_ok_o  (frames_ok),
    .frames_err_o (frames_err)
`endif
  );

  int errors = 0;
  int checks = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic beat_t mk(logic [1:0] adr, logic [1:0] sel, logic [15:0] dat, logic we);
    beat_t b;
    b.adr = adr; b.sel = sel; b.dat = dat; b.we = we;
    return b;
  endfunction

  function automatic fifo_entry_t get_out();
    fifo_entry_t e;
    e.sof = bus.out_sof_o; e.eof = bus.out_eof_o; e.err = bus.out_err_o;
    e.sel = bus.out_sel_o; e.dat = bus.out_dat_o;
    return e;
  endfunction

  // expected stream and frame counters, built from frame contents alone
  fifo_entry_t exp_q[$];
  fifo_entry_t popped[$];
  int exp_ok = 0;
  int exp_errf = 0;

  logic chk_en = 1'b0;
  logic exp_ack = 1'b0;
  logic exp_berr = 1'b0;
  int ack_cnt = 0;
  int berr_cnt = 0;

  task automatic model_frame(input beat_t bs[$]);
    beat_t w[$];
    fifo_entry_t e;
    logic ferr;
    ferr = 1'b0;
    foreach (bs[i]) begin
      if (bs[i].we) begin
        if (bs[i].adr == c_WRF_DATA) begin
          if (bs[i].sel == 2'b00) ferr = 1'b1;
          else w.push_back(bs[i]);
        end else if (bs[i].adr == c_WRF_STATUS && bs[i].dat[1]) begin
          ferr = 1'b1;
        end
      end
    end
    for (int i = 0; i < w.size() - 1; i++)
      if (w[i].sel != 2'b11) ferr = 1'b1;
    if (w.size() == 0) begin
      exp_errf++;
    end else begin
      for (int i = 0; i < w.size(); i++) begin
        e.sof = (i == 0);
        e.eof = (i == w.size() - 1);
        e.err = e.eof ? ferr : 1'b0;
        e.sel = w[i].sel;
        e.dat = w[i].dat;
        exp_q.push_back(e);
      end
      if (ferr) exp_errf++;
      else exp_ok++;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_ack  <= 1'b0;
      exp_berr <= 1'b0;
    end else if (chk_en) begin
      chk("ack", bus.snk_ack_o, exp_ack);
      chk("beat_err", bus.snk_err_o, exp_berr);
      if (bus.snk_ack_o) ack_cnt <= ack_cnt + 1;
      if (bus.snk_err_o) berr_cnt <= berr_cnt + 1;
      if (bus.out_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", bus.out_valid_o, 1'b0);
        end else begin
          chk("out_word", get_out(), exp_q[0]);
          if (bus.out_ready_i) begin
            popped.push_back(get_out());
            void'(exp_q.pop_front());
          end
        end
      end
      exp_ack  <= bus.snk_cyc_i & bus.snk_stb_i & ~bus.snk_stall_o & bus.snk_we_i;
      exp_berr <= bus.snk_cyc_i & bus.snk_stb_i & ~bus.snk_stall_o & ~bus.snk_we_i;
    end
  end

  task automatic drive_beat(input beat_t b);
    int g;
    g = 0;
    while (bus.snk_stall_o && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 500) chk("stall_timeout", bus.snk_stall_o, 1'b0);
    bus.snk_adr_i = b.adr;
    bus.snk_sel_i = b.sel;
    bus.snk_dat_i = b.dat;
    bus.snk_we_i  = b.we;
    bus.snk_stb_i = 1'b1;
    @(posedge clk); #1;
    bus.snk_stb_i = 1'b0;
  endtask

  task automatic send_frame(input beat_t bs[$]);
    model_frame(bs);
    bus.snk_cyc_i = 1'b1;
    foreach (bs[i]) drive_beat(bs[i]);
    bus.snk_cyc_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_valid_low"}, bus.out_valid_o, 1'b0);
  endtask

  task automatic check_stats(input string name);
`ifdef SWC_SINK_STATS_EN
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_frames_ok"}, frames_ok, exp_ok);
    chk({name, "_frames_err"}, frames_err, exp_errf);
`else
    repeat (3) @(posedge clk);
    #1;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    beat_t bq[$];
    int pb, ab, eb;

    bus.snk_dat_i = '0; bus.snk_adr_i = '0; bus.snk_sel_i = '0;
    bus.snk_cyc_i = 1'b0; bus.snk_stb_i = 1'b0; bus.snk_we_i = 1'b0;
    bus.out_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", bus.snk_stall_o, 1'b0);
    chk("rst_ack", bus.snk_ack_o, 1'b0);
    chk("rst_err", bus.snk_err_o, 1'b0);
    chk("rst_rty", bus.snk_rty_o, 1'b0);
    chk("rst_valid", bus.out_valid_o, 1'b0);
    chk("rst_out", get_out(), '0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // 1: four full words
    pb = popped.size(); ab = ack_cnt;
    bq.delete();
    for (int i = 1; i <= 4; i++) bq.push_back(mk(c_WRF_DATA, 2'b11, 16'(i * 16'h1111), 1'b1));
    send_frame(bq);
    chk("t1_last_valid", bus.out_valid_o, 1'b1);
    chk("t1_last_dat", bus.out_dat_o, 16'h4444);
    chk("t1_last_eof", bus.out_eof_o, 1'b1);
    drain("t1");
    chk("t1_acks", ack_cnt - ab, 4);
    chk("t1_words", popped.size() - pb, 4);
    if (popped.size() - pb == 4) begin
      chk("t1_first", popped[pb], {1'b1, 1'b0, 1'b0, 2'b11, 16'h1111});
      chk("t1_last", popped[pb + 3], {1'b0, 1'b1, 1'b0, 2'b11, 16'h4444});
    end
    check_stats("t1");

    // 2: odd-length frame ends in an upper-byte word
    pb = popped.size();
    bq.delete();
    bq.push_back(mk(c_WRF_DATA, 2'b11, 16'h0A0A, 1'b1));
    bq.push_back(mk(c_WRF_DATA, 2'b11, 16'h0B0B, 1'b1));
    bq.push_back(mk(c_WRF_DATA, 2'b10, 16'hAB00, 1'b1));
    send_frame(bq);
    drain("t2");
    chk("t2_words", popped.size() - pb, 3);
    if (popped.size() - pb == 3)
      chk("t2_last", popped[pb + 2], {1'b0, 1'b1, 1'b0, 2'b10, 16'hAB00});
    check_stats("t2");

    // 3: status beat with error bit
    pb = popped.size();
    bq.delete();
    bq.push_back(mk(c_WRF_DATA, 2'b11, 16'h0101, 1'b1));
    bq.push_back(mk(c_WRF_STATUS, 2'b11, 16'h0002, 1'b1));
    bq.push_back(mk(c_WRF_DATA, 2'b11, 16'h0202, 1'b1));
    send_frame(bq);
    drain("t3");
    chk("t3_words", popped.size() - pb, 2);
    if (popped.size() - pb == 2)
      chk("t3_last", popped[pb + 1], {1'b0, 1'b1, 1'b1, 2'b11, 16'h0202});
    check_stats("t3");

    // 4: back-pressure; 20 words with the consumer stalled
    pb = popped.size();
    bq.delete();
    for (int i = 0; i < 20; i++) bq.push_back(mk(c_WRF_DATA, 2'b11, 16'(16'h4000 + i), 1'b1));
    model_frame(bq);
    bus.out_ready_i = 1'b0;
    fork
      begin
        repeat (40) @(posedge clk);
        #1;
        bus.out_ready_i = 1'b1;
      end
    join_none
    bus.snk_cyc_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_beat(bq[i]);
      if (i == 12) chk("t4_stall_at_12", bus.snk_stall_o, 1'b0);
      if (i == 13) chk("t4_stall_at_13", bus.snk_stall_o, 1'b1);
    end
    bus.snk_cyc_i = 1'b0;
    @(posedge clk); #1;
    drain("t4");
    chk("t4_words", popped.size() - pb, 20);
    if (popped.size() - pb == 20)
      for (int i = 0; i < 20; i++) chk("t4_order", popped[pb + i].dat, 16'(16'h4000 + i));
    check_stats("t4");

    // 5: read strobe is refused
    ab = ack_cnt; eb = berr_cnt;
    bq.delete();
    bq.push_back(mk(c_WRF_DATA, 2'b11, 16'h7777, 1'b0));
    send_frame(bq);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_berr", berr_cnt - eb, 1);
    chk("t5_no_ack", ack_cnt - ab, 0);
    chk("t5_valid", bus.out_valid_o, 1'b0);
    check_stats("t5");

    // 6: reset mid-frame, remainder of the frame is dropped
    bus.snk_cyc_i = 1'b1;
    drive_beat(mk(c_WRF_DATA, 2'b11, 16'h5555, 1'b1));
    rst = 1'b1;
    exp_ok = 0; exp_errf = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    ab = ack_cnt;
    for (int i = 0; i < 3; i++) drive_beat(mk(c_WRF_DATA, 2'b11, 16'(16'h6661 + i), 1'b1));
    bus.snk_cyc_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_acks", ack_cnt - ab, 3);
    chk("t6_dropped", bus.out_valid_o, 1'b0);
    pb = popped.size();
    bq.delete();
    bq.push_back(mk(c_WRF_DATA, 2'b11, 16'h8888, 1'b1));
    bq.push_back(mk(c_WRF_DATA, 2'b11, 16'h9999, 1'b1));
    send_frame(bq);
    drain("t6");
    chk("t6_words", popped.size() - pb, 2);
    if (popped.size() - pb == 2) begin
      chk("t6_first", popped[pb], {1'b1, 1'b0, 1'b0, 2'b11, 16'h8888});
      chk("t6_last", popped[pb + 1], {1'b0, 1'b1, 1'b0, 2'b11, 16'h9999});
    end
    check_stats("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
